icache_fill_unit: RTL and testbench



---
 rtl/icache_fill_unit.sv | 135 +++++++++++++
 tb/tb_icache_fill_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/icache_fill_unit.sv
// Direct-mapped instruction cache with a single-outstanding miss handler.
// Lookups hit combinationally; misses request a block from the memory controller and fill one line.
`ifndef XLEN
`define XLEN 32
`endif

package icache_fill_unit_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic {
        DCACHE = 1'b0,
        ICACHE = 1'b1
    } DEST_CACHE;
endpackage

module icache_fill_unit
    import icache_fill_unit_pkg::*;
#(
    parameter int CACHE_LINES = 32,
    parameter int IDX_BITS    = $clog2(CACHE_LINES),
    parameter int TAG_BITS    = 32 - 3 - IDX_BITS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [`XLEN-1:0]  proc2Icache_addr,
    output logic [63:0]       Icache2proc_data,
    output logic              Icache2proc_valid,
    output BUS_COMMAND        icache_command,
    output logic [`XLEN-1:0]  icache_addr,
    input  logic [3:0]        control2cache_response,
    input  DEST_CACHE         control2cache_response_which,
    input  logic [63:0]       control2cache_data,
    input  logic [3:0]        control2cache_tag,
    input  DEST_CACHE         control2cache_tag_which
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                   state;
    logic [`XLEN-4:0]         miss_blk;
    logic [3:0]               miss_tag;

    logic [63:0]              line_data [CACHE_LINES];
    logic [TAG_BITS-1:0]      line_tag  [CACHE_LINES];
    logic [CACHE_LINES-1:0]   line_valid;

    logic [`XLEN-1:0]         fetch_aligned;
    logic [`XLEN-4:0]         fetch_blk;
    logic [IDX_BITS-1:0]      fetch_idx;
    logic [TAG_BITS-1:0]      fetch_tag;
    logic [IDX_BITS-1:0]      miss_idx;
    logic [TAG_BITS-1:0]      miss_tag_field;
    logic                     hit;
    logic                     grant;
    logic                     fill;

    assign fetch_aligned  = proc2Icache_addr & ~(`XLEN'(7));
    assign fetch_blk      = fetch_aligned[`XLEN-1:3];
    assign fetch_idx      = fetch_blk[IDX_BITS-1:0];
    assign fetch_tag      = fetch_blk[`XLEN-4:IDX_BITS];
    assign miss_idx       = miss_blk[IDX_BITS-1:0];
    assign miss_tag_field = miss_blk[`XLEN-4:IDX_BITS];

    assign hit   = line_valid[fetch_idx] && (line_tag[fetch_idx] == fetch_tag);
    assign grant = (control2cache_response != 4'd0) && (control2cache_response_which == ICACHE);
    // Reset gating here also guarantees a late tag after a mid-WAIT reset can never write a line.
    assign fill  = reset && (state == WAIT) && (control2cache_tag != 4'd0) &&
                   (control2cache_tag == miss_tag) && (control2cache_tag_which == ICACHE);

    always_comb begin
        Icache2proc_valid = reset && hit;
        Icache2proc_data  = (reset && hit) ? line_data[fetch_idx] : '0;
        icache_command    = BUS_NONE;
        icache_addr       = '0;
        if (reset && (state != WAIT) && !hit) begin
            icache_command = BUS_LOAD;
            icache_addr    = fetch_aligned;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            line_valid <= '0;
            miss_blk   <= '0;
            miss_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        miss_blk <= fetch_blk;
                        if (grant) begin
                            miss_tag <= control2cache_response;
                            state    <= WAIT;
                        end else begin
                            state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (hit) begin
                        state <= IDLE;
                    end else if (grant) begin
                        miss_tag <= control2cache_response;
                        miss_blk <= fetch_blk;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (fill) begin
                        line_valid[miss_idx] <= 1'b1;
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (fill) begin
            line_data[miss_idx] <= control2cache_data;
            line_tag[miss_idx]  <= miss_tag_field;
        end
    end

endmodule

// File: tb/tb_icache_fill_unit.sv
// Directed, table-driven bench for icache_fill_unit: one vector per clock cycle,
// combinational outputs checked mid-cycle against hand-computed expectations.
module tb_icache_fill_unit;
    import icache_fill_unit_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] proc2Icache_addr;
    logic [63:0] Icache2proc_data;
    logic        Icache2proc_valid;
    BUS_COMMAND  icache_command;
    logic [31:0] icache_addr;
    logic [3:0]  control2cache_response;
    DEST_CACHE   control2cache_response_which;
    logic [63:0] control2cache_data;
    logic [3:0]  control2cache_tag;
    DEST_CACHE   control2cache_tag_which;

    icache_fill_unit #(.CACHE_LINES(32)) dut (
        .clock                        (clock),
        .reset                        (reset),
        .proc2Icache_addr             (proc2Icache_addr),
        .Icache2proc_data             (Icache2proc_data),
        .Icache2proc_valid            (Icache2proc_valid),
        .icache_command               (icache_command),
        .icache_addr                  (icache_addr),
        .control2cache_response       (control2cache_response),
        .control2cache_response_which (control2cache_response_which),
        .control2cache_data           (control2cache_data),
        .control2cache_tag            (control2cache_tag),
        .control2cache_tag_which      (control2cache_tag_which)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [3:0]  resp;
        DEST_CACHE   resp_which;
        logic [3:0]  ctag;
        DEST_CACHE   ctag_which;
        logic [63:0] cdata;
        logic        exp_valid;
        logic [63:0] exp_data;
        BUS_COMMAND  exp_cmd;
        logic [31:0] exp_iaddr;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic rst, input logic [31:0] addr,
                                input logic [3:0] resp, input DEST_CACHE rw,
                                input logic [3:0] ctag, input DEST_CACHE tw,
                                input logic [63:0] cdata, input logic ev,
                                input logic [63:0] ed, input BUS_COMMAND ec,
                                input logic [31:0] ea);
        vec_t v;
        v.rst = rst; v.addr = addr; v.resp = resp; v.resp_which = rw;
        v.ctag = ctag; v.ctag_which = tw; v.cdata = cdata;
        v.exp_valid = ev; v.exp_data = ed; v.exp_cmd = ec; v.exp_iaddr = ea;
        return v;
    endfunction

    // Drive right after the edge, check mid-cycle, then let the next edge consume the inputs.
    task automatic run_vec(input vec_t v, input string name);
        reset                        = v.rst;
        proc2Icache_addr             = v.addr;
        control2cache_response       = v.resp;
        control2cache_response_which = v.resp_which;
        control2cache_tag            = v.ctag;
        control2cache_tag_which      = v.ctag_which;
        control2cache_data           = v.cdata;
        @(negedge clock);
        total++;
        if (Icache2proc_valid !== v.exp_valid) begin
            bad++;
            $display("FAIL %s valid: got %0b want %0b", name, Icache2proc_valid, v.exp_valid);
        end
        total++;
        if (Icache2proc_data !== v.exp_data) begin
            bad++;
            $display("FAIL %s data: got %h want %h", name, Icache2proc_data, v.exp_data);
        end
        total++;
        if (icache_command !== v.exp_cmd) begin
            bad++;
            $display("FAIL %s cmd: got %0d want %0d", name, icache_command, v.exp_cmd);
        end
        total++;
        if (icache_addr !== v.exp_iaddr) begin
            bad++;
            $display("FAIL %s iaddr: got %h want %h", name, icache_addr, v.exp_iaddr);
        end
        @(posedge clock);
        #1;
    endtask

    localparam logic [63:0] D_A = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D_B = 64'h6666_0000_0000_6666;
    localparam logic [63:0] D_C = 64'hA5A5_A5A5_5A5A_5A5A;
    localparam logic [63:0] D_D = 64'h0123_4567_89AB_CDEF;

    initial begin
        // reset, then cold miss at 0x100/0x104 with grant 3 and data 4 cycles later
        tbl.push_back(mk(0, 32'h100, 0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_NONE, 32'h0));
        tbl.push_back(mk(0, 32'h100, 0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h100, 0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_LOAD, 32'h100));
        tbl.push_back(mk(1, 32'h104, 3, ICACHE, 0, DCACHE, '0,     0, '0,  BUS_LOAD, 32'h100));
        tbl.push_back(mk(1, 32'h104, 0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h104, 0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h104, 0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h104, 0, DCACHE, 3, ICACHE, D_A,    0, '0,  BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h104, 0, DCACHE, 0, DCACHE, '0,     1, D_A, BUS_NONE, 32'h0));
        // DCACHE-owned grants ignored in REQ, then ICACHE grant 6
        tbl.push_back(mk(1, 32'h208, 5, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_LOAD, 32'h208));
        tbl.push_back(mk(1, 32'h208, 5, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_LOAD, 32'h208));
        tbl.push_back(mk(1, 32'h208, 5, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_LOAD, 32'h208));
        tbl.push_back(mk(1, 32'h208, 6, ICACHE, 0, DCACHE, '0,     0, '0,  BUS_LOAD, 32'h208));
        // wrong owner / wrong tag ignored in WAIT, then tag 6 fills
        tbl.push_back(mk(1, 32'h208, 0, DCACHE, 6, DCACHE, 64'h1111, 0, '0, BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h208, 0, DCACHE, 2, ICACHE, 64'h2222, 0, '0, BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h208, 0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h208, 0, DCACHE, 6, ICACHE, D_B,    0, '0,  BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h208, 0, DCACHE, 0, DCACHE, '0,     1, D_B, BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h100, 0, DCACHE, 0, DCACHE, '0,     1, D_A, BUS_NONE, 32'h0));
        // conflict eviction at index 0 with same-cycle grant from IDLE
        tbl.push_back(mk(1, 32'h2100, 7, ICACHE, 0, DCACHE, '0,    0, '0,  BUS_LOAD, 32'h2100));
        tbl.push_back(mk(1, 32'h2100, 0, DCACHE, 0, DCACHE, '0,    0, '0,  BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h2100, 0, DCACHE, 7, ICACHE, D_C,   0, '0,  BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h2100, 0, DCACHE, 0, DCACHE, '0,    1, D_C, BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h100, 0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_LOAD, 32'h100));
        // hit while in REQ drops the request
        tbl.push_back(mk(1, 32'h2100, 0, DCACHE, 0, DCACHE, '0,    1, D_C, BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h208, 0, DCACHE, 0, DCACHE, '0,     1, D_B, BUS_NONE, 32'h0));
        // address re-tracking in REQ, grant 4, then reset mid-WAIT
        tbl.push_back(mk(1, 32'h300, 0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_LOAD, 32'h300));
        tbl.push_back(mk(1, 32'h318, 4, ICACHE, 0, DCACHE, '0,     0, '0,  BUS_LOAD, 32'h318));
        tbl.push_back(mk(0, 32'h318, 0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_NONE, 32'h0));
        tbl.push_back(mk(1, 32'h318, 0, DCACHE, 4, ICACHE, 64'hBAD, 0, '0, BUS_LOAD, 32'h318));
        tbl.push_back(mk(1, 32'h318, 0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_LOAD, 32'h318));
        tbl.push_back(mk(1, 32'h104, 0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_LOAD, 32'h100));
        tbl.push_back(mk(0, 32'h0,   0, DCACHE, 0, DCACHE, '0,     0, '0,  BUS_NONE, 32'h0));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // fetch address moves during WAIT: original line still fills, new address handled from IDLE
        run_vec(mk(1, 32'h400, 9, ICACHE, 0, DCACHE, '0,  0, '0,  BUS_LOAD, 32'h400), "wchg_miss");
        run_vec(mk(1, 32'h208, 0, DCACHE, 0, DCACHE, '0,  0, '0,  BUS_NONE, 32'h0),   "wchg_wait");
        run_vec(mk(1, 32'h208, 0, DCACHE, 9, ICACHE, D_D, 0, '0,  BUS_NONE, 32'h0),   "wchg_fill");
        run_vec(mk(1, 32'h208, 0, DCACHE, 0, DCACHE, '0,  0, '0,  BUS_LOAD, 32'h208), "wchg_newmiss");
        run_vec(mk(1, 32'h400, 0, DCACHE, 0, DCACHE, '0,  1, D_D, BUS_NONE, 32'h0),   "wchg_hit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
